// File: rtl/screen_sequencer.sv
// Screen sequencer for the VGA game display.
// Walks the game through welcome, fade-out, play, level pause and game over,
// times the fade/pause/over screens in frames, selects the background source
// and registers the (optionally dimmed) background pixel.
//
// state   | meaning
// --------+-------------------------------------------------------------
// WELCOME | title screen, waiting for a start-key press
// FADE    | title screen dimming out over FADE_FRAMES frames
// GAME    | play in progress, object motion and collisions enabled
// PAUSE   | short hold after a level clear or a lost life
// OVER    | game-over screen, returns to WELCOME after OVER_FRAMES frames
module screen_sequencer #(
    parameter int FADE_FRAMES  = 16,
    parameter int PAUSE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180,
    parameter int START_LIVES  = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startKey,
    input  logic       playerHit,
    input  logic       levelCleared,
    input  logic [7:0] welcomeRGB,
    input  logic [7:0] gameRGB,
    input  logic [7:0] overRGB,
    output logic [7:0] BG_RGB,
    output logic       gameActive,
    output logic [2:0] screenState,
    output logic [1:0] livesLeft
);

    localparam int MAX_A   = (FADE_FRAMES > PAUSE_FRAMES) ? FADE_FRAMES : PAUSE_FRAMES;
    localparam int MAX_N   = (MAX_A > OVER_FRAMES) ? MAX_A : OVER_FRAMES;
    localparam int CNT_W   = ($clog2(MAX_N) > 8) ? $clog2(MAX_N) : 8;
    localparam int QUARTER = FADE_FRAMES / 4;

    typedef enum logic [2:0] {
        S_WELCOME = 3'd0,
        S_FADE    = 3'd1,
        S_GAME    = 3'd2,
        S_PAUSE   = 3'd3,
        S_OVER    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [1:0]         lives_q, lives_d;
    logic               key_prev_q, key_prev_d;
    logic [7:0]         bg_rgb_q, bg_rgb_d;

    logic               start_edge;
    logic [CNT_W-1:0]   dim_full;
    logic [1:0]         dim;

    assign start_edge = startKey & ~key_prev_q;

    // Next-state, lives and frame-counter logic; the counter restarts on every state change.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        frame_cnt_d = frame_cnt_q;
        key_prev_d  = startKey;
        case (state_q)
            S_WELCOME: begin
                if (start_edge) begin
                    state_d = S_FADE;
                    lives_d = 2'(START_LIVES);
                end
            end
            S_FADE: begin
                if (startOfFrame) begin
                    if (frame_cnt_q == CNT_W'(FADE_FRAMES - 1)) state_d = S_GAME;
                    else frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            S_GAME: begin
                if (playerHit) begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q <= 2'd1) ? S_OVER : S_PAUSE;
                end else if (levelCleared) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (startOfFrame) begin
                    if (frame_cnt_q == CNT_W'(PAUSE_FRAMES - 1)) state_d = S_GAME;
                    else frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            S_OVER: begin
                if (startOfFrame) begin
                    if (frame_cnt_q == CNT_W'(OVER_FRAMES - 1)) state_d = S_WELCOME;
                    else frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_WELCOME;
        endcase
        if (state_d != state_q) frame_cnt_d = '0;
    end

    // Background source select, with per-field right shift while fading.
    always_comb begin
        dim_full = frame_cnt_q / CNT_W'(QUARTER);
        dim      = dim_full[1:0];
        bg_rgb_d = 8'h00;
        case (state_q)
            S_WELCOME:       bg_rgb_d = welcomeRGB;
            S_FADE:          bg_rgb_d = {welcomeRGB[7:5] >> dim,
                                         welcomeRGB[4:2] >> dim,
                                         welcomeRGB[1:0] >> dim};
            S_GAME, S_PAUSE: bg_rgb_d = gameRGB;
            S_OVER:          bg_rgb_d = overRGB;
            default:         bg_rgb_d = 8'h00;
        endcase
    end

    // State and datapath registers; key_prev resets high so a held key cannot start a game.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_WELCOME;
            frame_cnt_q <= '0;
            lives_q     <= 2'(START_LIVES);
            key_prev_q  <= 1'b1;
            bg_rgb_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lives_q     <= lives_d;
            key_prev_q  <= key_prev_d;
            bg_rgb_q    <= bg_rgb_d;
        end
    end

    assign BG_RGB      = bg_rgb_q;
    assign gameActive  = (state_q == S_GAME);
    assign screenState = state_q;
    assign livesLeft   = lives_q;

endmodule
